// File: rtl/rsp_s2_prep_pkg.sv
// rsp_s2_prep_pkg
//   Shared types and constants for the S2 preparation blocks. Holds the
//   twiddle loader FSM state type, table/word sizing and the {re,im}
//   field positions inside a RAM0 table word.
package rsp_s2_prep_pkg;

  localparam int RAM0_ADDR_WIDTH = 11;
  localparam int RAM_DATA_WIDTH  = 64;
  localparam int TWIDDLE_NUM     = 136;
  localparam int RAM_DELAY       = 2;

  // Wide enough to hold a full word count (0..TWIDDLE_NUM), not just an address
  localparam int TWID_CNT_WIDTH  = $clog2(TWIDDLE_NUM + 1);

  // Table word layout: {re[63:32], im[31:0]}
  localparam int RE_MSB = 63;
  localparam int RE_LSB = 32;
  localparam int IM_MSB = 31;
  localparam int IM_LSB = 0;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FIN   = 3'd3,
    ST_CHECK = 3'd4,
    ST_DONE  = 3'd5
  } twid_ld_state_t;

endpackage

// File: rtl/rsp_s2_prep_twid_chk.sv
// rsp_s2_prep_twid_chk
//   Readback checksum helper for the twiddle loader. Folds every word
//   written to RAM0 into one XOR accumulator and every word read back
//   (RAM_DELAY cycles after its read was presented) into another.
// Ports
//   clk, rst_n   core clock, async active-low reset
//   clear        zero both accumulators and the read pipe
//   wr_fold      a RAM0 write is on the bus this cycle; wr_data is its word
//   rd_issue     a RAM0 read is on the bus this cycle
//   rd_data      RAM0 read data
//   rd_pending   a read is on the bus or still in flight
//   mismatch     write and readback accumulators differ
module rsp_s2_prep_twid_chk
  import rsp_s2_prep_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear,
  input  logic                      wr_fold,
  input  logic [RAM_DATA_WIDTH-1:0] wr_data,
  input  logic                      rd_issue,
  input  logic [RAM_DATA_WIDTH-1:0] rd_data,
  output logic                      rd_pending,
  output logic                      mismatch
);

  logic [RAM_DELAY-1:0]      rd_pipe;
  logic [RAM_DATA_WIDTH-1:0] wr_acc;
  logic [RAM_DATA_WIDTH-1:0] rd_acc;

  // The top bit of rd_pipe marks the cycle in which the read data for a
  // read presented RAM_DELAY cycles earlier is valid on rd_data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pipe <= '0;
      wr_acc  <= '0;
      rd_acc  <= '0;
    end else if (clear) begin
      rd_pipe <= '0;
      wr_acc  <= '0;
      rd_acc  <= '0;
    end else begin
      rd_pipe <= RAM_DELAY'({rd_pipe, rd_issue});
      if (wr_fold)
        wr_acc <= wr_acc ^ wr_data;
      if (rd_pipe[RAM_DELAY-1])
        rd_acc <= rd_acc ^ rd_data;
    end
  end

  assign rd_pending = rd_issue | (|rd_pipe);
  assign mismatch   = (rd_acc != wr_acc);

endmodule

// File: rtl/rsp_s2_prep_pg_twid_loader.sv
// rsp_s2_prep_pg_twid_loader
//   Writer side of the phase-generation twiddle RAM0 port. Takes the octant
//   twiddle table as a valid/ready stream and writes it into RAM0 at
//   addresses 0..TWIDDLE_NUM-1, one registered write per accepted beat.
//   Flags a table whose tlast is not on entry TWIDDLE_NUM-1 and reports done.
// Optional feature macro: TWID_LOAD_CHECK_EN
//   When defined, the written table is read back after the load and an
//   XOR checksum of the readback is compared against the written words.
// Ports
//   clk, rst_n                 core clock, async active-low reset
//   i_load_start               pulse: begin a table load (ignored while busy)
//   s_tdata/s_tvalid/s_tlast   table word stream in; s_tready out
//   o_ram0_addra/ena/wena/dina RAM0 port A drive (wena=1 write)
//   i_ram0_douta               RAM0 read data (readback check only)
//   o_busy                     load in progress
//   o_done                     table complete, held until next start
//   o_err_len                  tlast misplaced, held until next start
//   o_chk_fail                 readback mismatch (0 when check compiled out)
module rsp_s2_prep_pg_twid_loader
  import rsp_s2_prep_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_load_start,
  input  logic [RAM_DATA_WIDTH-1:0]  s_tdata,
  input  logic                       s_tvalid,
  input  logic                       s_tlast,
  output logic                       s_tready,
  output logic [RAM0_ADDR_WIDTH-1:0] o_ram0_addra,
  output logic                       o_ram0_ena,
  output logic                       o_ram0_wena,
  output logic [RAM_DATA_WIDTH-1:0]  o_ram0_dina,
  input  logic [RAM_DATA_WIDTH-1:0]  i_ram0_douta,
  output logic                       o_busy,
  output logic                       o_done,
  output logic                       o_err_len,
  output logic                       o_chk_fail
);

  localparam logic [TWID_CNT_WIDTH-1:0] CNT_LAST = TWID_CNT_WIDTH'(TWIDDLE_NUM - 1);

  twid_ld_state_t state_q, state_d;

  logic [TWID_CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [RAM0_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                       ena_q, ena_d;
  logic                       wena_q, wena_d;
  logic [RAM_DATA_WIDTH-1:0]  dina_q, dina_d;
  logic                       err_len_q, err_len_d;
  logic                       ready;

`ifdef TWID_LOAD_CHECK_EN
  logic [TWID_CNT_WIDTH-1:0]  wcnt_q, wcnt_d;
  logic                       chk_fail_q, chk_fail_d;
  logic                       chk_clear;
  logic                       rd_pending;
  logic                       chk_mismatch;
`endif

  assign ready = (state_q == ST_LOAD) || (state_q == ST_DRAIN);

  // Next-state and next RAM-port values. RAM0 drive is registered, so every
  // accepted beat appears on the RAM port exactly one cycle later. cnt is the
  // write address and saturates at the last table entry; in the check build
  // it is reused as the readback address.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    ena_d     = 1'b0;
    wena_d    = 1'b0;
    dina_d    = dina_q;
    err_len_d = err_len_q;
`ifdef TWID_LOAD_CHECK_EN
    wcnt_d     = wcnt_q;
    chk_fail_d = chk_fail_q;
    chk_clear  = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_load_start) begin
          state_d   = ST_LOAD;
          cnt_d     = '0;
          err_len_d = 1'b0;
`ifdef TWID_LOAD_CHECK_EN
          wcnt_d     = '0;
          chk_fail_d = 1'b0;
          chk_clear  = 1'b1;
`endif
        end
      end
      ST_LOAD: begin
        if (s_tvalid) begin
          ena_d  = 1'b1;
          wena_d = 1'b1;
          addr_d = RAM0_ADDR_WIDTH'(cnt_q);
          dina_d = {s_tdata[RE_MSB:RE_LSB], s_tdata[IM_MSB:IM_LSB]};
`ifdef TWID_LOAD_CHECK_EN
          wcnt_d = wcnt_q + 1'b1;
`endif
          if (cnt_q != CNT_LAST)
            cnt_d = cnt_q + 1'b1;
          if (s_tlast) begin
            state_d = ST_FIN;
            if (cnt_q != CNT_LAST)
              err_len_d = 1'b1;
          end else if (cnt_q == CNT_LAST) begin
            // Table overran: keep accepting but drop beats until tlast
            state_d   = ST_DRAIN;
            err_len_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (s_tvalid && s_tlast)
          state_d = ST_FIN;
      end
      ST_FIN: begin
`ifdef TWID_LOAD_CHECK_EN
        state_d = ST_CHECK;
        cnt_d   = '0;
`else
        state_d = ST_DONE;
`endif
      end
      ST_CHECK: begin
`ifdef TWID_LOAD_CHECK_EN
        // Issue one read per cycle over the written range, then wait for
        // the last read data to be folded before comparing.
        if (cnt_q < wcnt_q) begin
          ena_d  = 1'b1;
          addr_d = RAM0_ADDR_WIDTH'(cnt_q);
          cnt_d  = cnt_q + 1'b1;
        end else if (!rd_pending) begin
          chk_fail_d = chk_mismatch;
          state_d    = ST_DONE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Counter, RAM port and status registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      addr_q    <= '0;
      ena_q     <= 1'b0;
      wena_q    <= 1'b0;
      dina_q    <= '0;
      err_len_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      ena_q     <= ena_d;
      wena_q    <= wena_d;
      dina_q    <= dina_d;
      err_len_q <= err_len_d;
    end
  end

`ifdef TWID_LOAD_CHECK_EN
  // Written-word count and check result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt_q     <= '0;
      chk_fail_q <= 1'b0;
    end else begin
      wcnt_q     <= wcnt_d;
      chk_fail_q <= chk_fail_d;
    end
  end

  rsp_s2_prep_twid_chk u_chk (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (chk_clear),
    .wr_fold    (ena_q & wena_q),
    .wr_data    (dina_q),
    .rd_issue   (ena_q & ~wena_q),
    .rd_data    (i_ram0_douta),
    .rd_pending (rd_pending),
    .mismatch   (chk_mismatch)
  );

  assign o_chk_fail = chk_fail_q;
`else
  logic unused_douta;
  assign unused_douta = ^i_ram0_douta;
  assign o_chk_fail   = 1'b0;
`endif

  assign s_tready     = ready;
  assign o_ram0_addra = addr_q;
  assign o_ram0_ena   = ena_q;
  assign o_ram0_wena  = wena_q;
  assign o_ram0_dina  = dina_q;
  assign o_err_len    = err_len_q;
  assign o_done       = (state_q == ST_DONE);
  assign o_busy       = (state_q == ST_LOAD) || (state_q == ST_DRAIN) ||
                        (state_q == ST_FIN)  || (state_q == ST_CHECK);

endmodule

// File: tb/tb_rsp_s2_prep_pg_twid_loader.sv
// tb_rsp_s2_prep_pg_twid_loader
//   Self-checking bench for the twiddle RAM0 loader. A behavioural model
//   tracks what the loader must show each cycle (ready, busy, done, error,
//   and which RAM write must be on the port) from the table rules; a RAM
//   model with RAM_DELAY read latency sits on the RAM0 port.
//   Define TWID_LOAD_CHECK_EN to also exercise the readback checksum.
module tb_rsp_s2_prep_pg_twid_loader;
  import rsp_s2_prep_pkg::*;

  localparam int TN = TWIDDLE_NUM;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_load_start = 1'b0;
  logic [63:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tlast = 1'b0;
  logic        s_tready;
  logic [10:0] o_ram0_addra;
  logic        o_ram0_ena;
  logic        o_ram0_wena;
  logic [63:0] o_ram0_dina;
  logic [63:0] ramDout;
  logic        o_busy;
  logic        o_done;
  logic        o_err_len;
  logic        o_chk_fail;

  int numChecks = 0;
  int numErrors = 0;

  // Behavioural model of the observable outputs
  bit          chkOn = 1'b0;
  bit          mBusy = 1'b0;
  bit          mReady = 1'b0;
  bit          mDone = 1'b0;
  bit          mErr = 1'b0;
  bit          mChkFail = 1'b0;
  bit          mInCheck = 1'b0;
  bit          expWr = 1'b0;
  logic [10:0] expAddr = '0;
  logic [63:0] expData = '0;

  // RAM model state
  logic [63:0] ramMem [0:2047];
  logic [63:0] refImg [0:TN-1];
  logic [63:0] rdStage;
  bit          clearReq = 1'b0;
  bit          flipBit17 = 1'b0;
  int          totalWr = 0;
  int          wrBase = 0;

  always #5 clk = ~clk;

  rsp_s2_prep_pg_twid_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_load_start (i_load_start),
    .s_tdata      (s_tdata),
    .s_tvalid     (s_tvalid),
    .s_tlast      (s_tlast),
    .s_tready     (s_tready),
    .o_ram0_addra (o_ram0_addra),
    .o_ram0_ena   (o_ram0_ena),
    .o_ram0_wena  (o_ram0_wena),
    .o_ram0_dina  (o_ram0_dina),
    .i_ram0_douta (ramDout),
    .o_busy       (o_busy),
    .o_done       (o_done),
    .o_err_len    (o_err_len),
    .o_chk_fail   (o_chk_fail)
  );

  // RAM0 model: synchronous write, RAM_DELAY(=2)-cycle read, optional
  // bit-0 corruption of address 17 on readback.
  always @(posedge clk) begin
    if (clearReq) begin
      for (int i = 0; i < TN; i++) ramMem[i] <= '0;
    end else if (o_ram0_ena && o_ram0_wena) begin
      ramMem[o_ram0_addra] <= o_ram0_dina;
      totalWr <= totalWr + 1;
    end
    rdStage <= ramMem[o_ram0_addra] ^ ((flipBit17 && o_ram0_addra == 11'd17) ? 64'd1 : 64'd0);
    ramDout <= rdStage;
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    numChecks++;
    if (act !== exp) begin
      numErrors++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chkOn) begin
      checkOutput("s_tready", s_tready, mReady);
      checkOutput("o_err_len", o_err_len, mErr);
      checkOutput("o_chk_fail", o_chk_fail, mChkFail);
      if (!mInCheck) begin
        checkOutput("o_busy", o_busy, mBusy);
        checkOutput("o_done", o_done, mDone);
        checkOutput("ram_ena", o_ram0_ena, expWr);
        checkOutput("ram_wena", o_ram0_wena, expWr);
        if (expWr && o_ram0_ena) begin
          checkOutput("ram_addr", o_ram0_addra, expAddr);
          checkOutput("ram_dina", o_ram0_dina, expData);
        end
      end
    end
  end

  task automatic startLoad();
    i_load_start = 1'b1;
    wrBase = totalWr;
    @(posedge clk);
    mBusy = 1'b1; mReady = 1'b1; mDone = 1'b0; mErr = 1'b0; mChkFail = 1'b0; expWr = 1'b0;
    #1 i_load_start = 1'b0;
  endtask

  // One table load: beats 0..lastIdx with tlast on lastIdx, random gaps of
  // gapPct percent, sequential (addr*0x00010001) or random data. If abortAt
  // >= 0, reset is asserted instead of presenting that beat.
  task automatic applyStimulus(input int lastIdx, input int gapPct, input bit seqData, input int abortAt);
    logic [63:0] data;
    startLoad();
    for (int b = 0; b <= lastIdx; b++) begin
      if (b == abortAt) begin
        rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0;
        mBusy = 1'b0; mReady = 1'b0; mDone = 1'b0; mErr = 1'b0; mChkFail = 1'b0; expWr = 1'b0;
        return;
      end
      while (gapPct > 0 && $urandom_range(99) < gapPct) begin
        s_tvalid = 1'b0; s_tlast = 1'b0;
        @(posedge clk);
        expWr = 1'b0;
        #1;
      end
      data = seqData ? 64'(b) * 64'h0000_0000_0001_0001 : {$urandom, $urandom};
      s_tvalid = 1'b1; s_tdata = data; s_tlast = (b == lastIdx);
      @(posedge clk);
      // Only the first TN beats of a table reach the RAM
      expWr = (b < TN); expAddr = 11'(b); expData = data;
      // Length error: tlast anywhere but entry TN-1 (known at tlast or at entry TN-1)
      if ((b == lastIdx && b < TN - 1) || (b == TN - 1 && b != lastIdx)) mErr = 1'b1;
      if (b == lastIdx) mReady = 1'b0;
      #1;
    end
    s_tvalid = 1'b0; s_tlast = 1'b0;
    @(posedge clk);
    expWr = 1'b0;
`ifdef TWID_LOAD_CHECK_EN
    mInCheck = 1'b1;
    #1;
    for (int n = 0; n < 3000 && !o_done; n++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("done_after_check", o_done, 1'b1);
    mInCheck = 1'b0; mBusy = 1'b0; mDone = 1'b1; mChkFail = flipBit17;
`else
    mBusy = 1'b0; mDone = 1'b1;
    #1;
`endif
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    $display("[TB] reset state");
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_busy", o_busy, 1'b0);
    checkOutput("rst_done", o_done, 1'b0);
    checkOutput("rst_ready", s_tready, 1'b0);
    checkOutput("rst_ena", o_ram0_ena, 1'b0);
    checkOutput("rst_wena", o_ram0_wena, 1'b0);
    checkOutput("rst_addr", o_ram0_addra, 11'd0);
    checkOutput("rst_dina", o_ram0_dina, 64'd0);
    checkOutput("rst_err", o_err_len, 1'b0);
    checkOutput("rst_chk", o_chk_fail, 1'b0);
    rst_n = 1'b1;
    chkOn = 1'b1;
    idleCycles(2);

    $display("[TB] case 1: full table, no gaps");
    applyStimulus(TN - 1, 0, 1'b1, -1);
    checkOutput("c1_wr_count", 64'(totalWr - wrBase), 64'd136);
    checkOutput("c1_mem5", ramMem[5], 64'h0000_0000_0005_0005);
    checkOutput("c1_mem135", ramMem[135], 64'h0000_0000_0087_0087);
    checkOutput("c1_err", o_err_len, 1'b0);
    for (int i = 0; i < TN; i++) refImg[i] = ramMem[i];
    clearReq = 1'b1;
    @(posedge clk);
    #1 clearReq = 1'b0;
    checkOutput("c1_cleared", ramMem[5], 64'd0);
    idleCycles(3);

    $display("[TB] case 2: 50%% valid gaps");
    applyStimulus(TN - 1, 50, 1'b1, -1);
    checkOutput("c2_wr_count", 64'(totalWr - wrBase), 64'd136);
    for (int i = 0; i < TN; i++) checkOutput("c2_image", ramMem[i], refImg[i]);
    idleCycles(2);

    $display("[TB] case 3: short table, tlast on beat 99");
    applyStimulus(99, 30, 1'b0, -1);
    checkOutput("c3_wr_count", 64'(totalWr - wrBase), 64'd100);
    checkOutput("c3_err", o_err_len, 1'b1);
    checkOutput("c3_done", o_done, 1'b1);
    idleCycles(2);

    $display("[TB] case 4: long table, tlast on beat 139");
    applyStimulus(139, 25, 1'b0, -1);
    checkOutput("c4_wr_count", 64'(totalWr - wrBase), 64'd136);
    checkOutput("c4_err", o_err_len, 1'b1);
    idleCycles(2);

    $display("[TB] case 5: reset at beat 60, then reload");
    applyStimulus(TN - 1, 0, 1'b1, 60);
    @(negedge clk);
    checkOutput("c5_busy", o_busy, 1'b0);
    checkOutput("c5_done", o_done, 1'b0);
    checkOutput("c5_ready", s_tready, 1'b0);
    checkOutput("c5_ena", o_ram0_ena, 1'b0);
    checkOutput("c5_wena", o_ram0_wena, 1'b0);
    checkOutput("c5_addr", o_ram0_addra, 11'd0);
    checkOutput("c5_dina", o_ram0_dina, 64'd0);
    checkOutput("c5_err", o_err_len, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    idleCycles(1);
    applyStimulus(TN - 1, 20, 1'b1, -1);
    checkOutput("c5_wr_count", 64'(totalWr - wrBase), 64'd136);
    checkOutput("c5_mem0", ramMem[0], 64'd0);
    checkOutput("c5_mem60", ramMem[60], 64'h0000_0000_003c_003c);
    idleCycles(2);

`ifdef TWID_LOAD_CHECK_EN
    $display("[TB] case 6: readback checksum");
    flipBit17 = 1'b0;
    applyStimulus(TN - 1, 10, 1'b0, -1);
    checkOutput("c6_clean", o_chk_fail, 1'b0);
    idleCycles(2);
    flipBit17 = 1'b1;
    applyStimulus(TN - 1, 10, 1'b0, -1);
    checkOutput("c6_flip", o_chk_fail, 1'b1);
    flipBit17 = 1'b0;
    idleCycles(2);
`endif

    chkOn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", numChecks, numErrors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] watchdog");
  end

endmodule
